// File: rtl/uart_boot_loader.sv
// Boot-time loader: packs UART bytes big-endian into 32-bit words and writes them to DDR
// through a MIG user port as fixed-length bursts, then raises boot_done.
module uart_boot_loader #(
   parameter int unsigned IMAGE_BYTES = 65536,
   parameter int unsigned BURST_WORDS = 16,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        boot_done,
   output logic        boot_error,
   output logic        mem_cmd_en,
   output logic [2:0]  mem_cmd_instr,
   output logic [5:0]  mem_cmd_bl,
   output logic [29:0] mem_cmd_byte_addr,
   input  logic        mem_cmd_full,
   output logic        mem_wr_en,
   output logic [3:0]  mem_wr_mask,
   output logic [31:0] mem_wr_data,
   input  logic        mem_wr_full,
   input  logic        mem_wr_empty,
   input  logic        mem_wr_underrun,
   input  logic        mem_wr_error,
   output logic [1:0]  cmd_state_dbg
);

   localparam int unsigned NUM_BURSTS = IMAGE_BYTES / (4 * BURST_WORDS);
   localparam int BC_W = $clog2(IMAGE_BYTES + 1);
   localparam int WB_W = $clog2(BURST_WORDS + 1);
   localparam int NB_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_ISSUE = 2'd1,
      C_DRAIN = 2'd2,
      C_DONE  = 2'd3
   } cmd_state_t;

   cmd_state_t      state;
   logic [BC_W-1:0] byte_cnt;
   logic [23:0]     word_acc;
   logic            word_pending;
   logic [WB_W-1:0] words_in_burst;
   logic [NB_W-1:0] burst_idx;
   logic [29:0]     cur_addr;

   logic accept, word_done, burst_end, last_burst, overflow, issue_overlap;

   assign mem_cmd_instr = 3'b000;
   assign mem_wr_mask   = 4'b0000;
   assign cmd_state_dbg = state;

   assign accept     = rx_valid && (byte_cnt != BC_W'(IMAGE_BYTES)) && !boot_error;
   assign word_done  = accept && (byte_cnt[1:0] == 2'd3);

   // Strobes look at the MIG full flags in the same cycle so nothing is pushed into a full FIFO.
   assign mem_wr_en  = word_pending && !mem_wr_full && !boot_error;
   assign mem_cmd_en = (state == C_ISSUE) && !mem_cmd_full && !boot_error;

   assign burst_end     = mem_wr_en && (words_in_burst == WB_W'(BURST_WORDS - 1));
   assign last_burst    = (burst_idx == NB_W'(NUM_BURSTS - 1));
   assign overflow      = word_done && word_pending && !mem_wr_en;
   assign issue_overlap = burst_end && (state == C_ISSUE) && !mem_cmd_en;
   assign cur_addr      = 30'(BASE_ADDR) + 30'(burst_idx) * 30'(BURST_WORDS * 4);

   // Byte packer and single-entry hold register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt     <= '0;
         word_acc     <= '0;
         word_pending <= 1'b0;
         mem_wr_data  <= '0;
      end else begin
         if (accept) begin
            byte_cnt <= byte_cnt + BC_W'(1);
            word_acc <= {word_acc[15:0], rx_data};
         end
         if (word_done) begin
            mem_wr_data  <= {word_acc, rx_data};
            word_pending <= 1'b1;
         end else if (mem_wr_en) begin
            word_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         boot_error <= 1'b0;
      end else if (mem_wr_underrun || mem_wr_error || overflow || issue_overlap) begin
         boot_error <= 1'b1;
      end
   end

   // Command FSM; everything freezes once boot_error is set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= C_IDLE;
         words_in_burst    <= '0;
         burst_idx         <= '0;
         boot_done         <= 1'b0;
         mem_cmd_bl        <= '0;
         mem_cmd_byte_addr <= '0;
      end else begin
         mem_cmd_bl        <= 6'(BURST_WORDS - 1);
         // Track the address of the burst that will be issued next, also right after a fire.
         mem_cmd_byte_addr <= mem_cmd_en ? (cur_addr + 30'(BURST_WORDS * 4)) : cur_addr;
         if (!boot_error) begin
            if (mem_wr_en) begin
               words_in_burst <= burst_end ? '0 : words_in_burst + WB_W'(1);
            end
            case (state)
               C_IDLE: begin
                  if (burst_end) state <= C_ISSUE;
               end
               C_ISSUE: begin
                  if (mem_cmd_en) begin
                     burst_idx <= burst_idx + NB_W'(1);
                     if (last_burst)     state <= C_DRAIN;
                     else if (burst_end) state <= C_ISSUE;
                     else                state <= C_IDLE;
                  end
               end
               C_DRAIN: begin
                  if (mem_wr_empty) state <= C_DONE;
               end
               C_DONE: begin
                  boot_done <= 1'b1;
               end
               default: state <= C_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a 128-byte image and 16-word bursts.
module tb_uart_boot_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        boot_done, boot_error;
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_cmd_full = 1'b0;
   logic        mem_wr_en;
   logic [3:0]  mem_wr_mask;
   logic [31:0] mem_wr_data;
   logic        mem_wr_full = 1'b0;
   logic        mem_wr_empty = 1'b0;
   logic        mem_wr_underrun = 1'b0;
   logic        mem_wr_error = 1'b0;
   logic [1:0]  cmd_state_dbg;

   uart_boot_loader #(.IMAGE_BYTES(128), .BURST_WORDS(16), .BASE_ADDR(0)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .boot_done(boot_done), .boot_error(boot_error),
      .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
      .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
      .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
      .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty),
      .mem_wr_underrun(mem_wr_underrun), .mem_wr_error(mem_wr_error),
      .cmd_state_dbg(cmd_state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   // ---------------- monitor (samples on the falling edge) ----------------
   logic [31:0] wr_log[$];
   int          wr_cyc[$];
   logic [29:0] cmd_log[$];
   int          cmd_cyc[$];
   int          bad_const = 0;
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (mem_wr_en) begin
         wr_log.push_back(mem_wr_data);
         wr_cyc.push_back(cyc);
         if (mem_wr_mask !== 4'b0000) bad_const++;
      end
      if (mem_cmd_en) begin
         cmd_log.push_back(mem_cmd_byte_addr);
         cmd_cyc.push_back(cyc);
         if (mem_cmd_bl !== 6'd15 || mem_cmd_instr !== 3'b000) bad_const++;
      end
   end

   // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      wr_cyc.delete();
      cmd_log.delete();
      cmd_cyc.delete();
      exp_q.delete();
      bad_const = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rx_valid = 1'b0;
      mem_cmd_full = 1'b0;
      mem_wr_full = 1'b0;
      mem_wr_empty = 1'b0;
      mem_wr_underrun = 1'b0;
      mem_wr_error = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(1);
      clear_logs();
   endtask

   // One strobe per byte, then `gap` idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_valid = 1'b1;
      idle(1);
      rx_valid = 1'b0;
      idle(gap);
   endtask

   task automatic send_range(input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) send_byte(8'(i), gap);
   endtask

   task automatic build_exp(input int nwords);
      exp_q.delete();
      for (int i = 0; i < nwords; i++)
         exp_q.push_back({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      idle(3);
      n_cmp++;
      if ({boot_done, boot_error, mem_cmd_en, mem_wr_en, mem_cmd_bl, mem_cmd_byte_addr, mem_wr_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got done=%b err=%b cen=%b wen=%b bl=%0d addr=%0h data=%0h required all 0",
                  boot_done, boot_error, mem_cmd_en, mem_wr_en, mem_cmd_bl, mem_cmd_byte_addr, mem_wr_data);
      end
      reset_n = 1'b1;
      idle(2);
      n_cmp++;
      if (mem_cmd_bl !== 6'd15) begin
         n_fail++;
         $display("FAIL reset_bl_after: got %0d required 15", mem_cmd_bl);
      end
      n_cmp++;
      if (cmd_state_dbg !== 2'd0 || boot_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got state=%0d done=%b required 0 0", cmd_state_dbg, boot_done);
      end
   endtask

   task automatic test_basic_load();
      int byte3_cyc;
      do_reset();
      for (int i = 0; i < 128; i++) begin
         if (i == 3) byte3_cyc = cyc;
         send_byte(8'(i), 2);
      end
      idle(5);
      n_cmp++;
      if (wr_log.size() != 32) begin
         n_fail++;
         $display("FAIL basic_word_count: got %0d required 32", wr_log.size());
      end
      n_cmp++;
      if (wr_cyc.size() == 0 || wr_cyc[0] != byte3_cyc + 1) begin
         n_fail++;
         $display("FAIL basic_push_latency: got cycle %0d required %0d", (wr_cyc.size() != 0) ? wr_cyc[0] : -1, byte3_cyc + 1);
      end
      build_exp(32);
      for (int i = 0; i < 32 && i < wr_log.size(); i++) begin
         n_cmp++;
         if (wr_log[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL basic_word[%0d]: got %08h required %08h", i, wr_log[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (cmd_log.size() != 2 || cmd_log[0] !== 30'h0 || cmd_log[1] !== 30'h40) begin
         n_fail++;
         $display("FAIL basic_cmds: got count=%0d addr0=%0h addr1=%0h required 2 0 40", cmd_log.size(),
                  (cmd_log.size() > 0) ? cmd_log[0] : 30'h3fffffff, (cmd_log.size() > 1) ? cmd_log[1] : 30'h3fffffff);
      end
      n_cmp++;
      if (bad_const != 0) begin
         n_fail++;
         $display("FAIL basic_bl_instr_mask: got %0d bad strobes required 0", bad_const);
      end
      n_cmp++;
      if (boot_done !== 1'b0 || cmd_state_dbg !== 2'd2) begin
         n_fail++;
         $display("FAIL basic_wait_drain: got done=%b state=%0d required 0 2", boot_done, cmd_state_dbg);
      end
      mem_wr_empty = 1'b1;
      idle(1);
      n_cmp++;
      if (boot_done !== 1'b0 || cmd_state_dbg !== 2'd3) begin
         n_fail++;
         $display("FAIL basic_done_entry: got done=%b state=%0d required 0 3", boot_done, cmd_state_dbg);
      end
      idle(1);
      n_cmp++;
      if (boot_done !== 1'b1 || boot_error !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b err=%b required 1 0", boot_done, boot_error);
      end
   endtask

   task automatic test_wr_full();
      int c0;
      do_reset();
      send_range(0, 2, 2);
      mem_wr_full = 1'b1;
      c0 = cyc;
      send_byte(8'd3, 5);
      n_cmp++;
      if (wr_log.size() != 0) begin
         n_fail++;
         $display("FAIL full_held: got %0d pushes required 0", wr_log.size());
      end
      mem_wr_full = 1'b0;
      idle(2);
      send_range(4, 127, 2);
      idle(5);
      n_cmp++;
      if (wr_cyc.size() == 0 || wr_cyc[0] != c0 + 6 || wr_log[0] !== 32'h00010203) begin
         n_fail++;
         $display("FAIL full_release_push: got cycle %0d required %0d", (wr_cyc.size() != 0) ? wr_cyc[0] : -1, c0 + 6);
      end
      n_cmp++;
      if (wr_log.size() != 32 || boot_error !== 1'b0 || wr_log[31] !== 32'h7C7D7E7F) begin
         n_fail++;
         $display("FAIL full_rest: got count=%0d err=%b required 32 0", wr_log.size(), boot_error);
      end

      do_reset();
      mem_wr_full = 1'b1;
      send_range(0, 6, 2);
      n_cmp++;
      if (boot_error !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_early: got err=%b required 0", boot_error);
      end
      send_byte(8'd7, 2);
      n_cmp++;
      if (boot_error !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_err: got err=%b required 1", boot_error);
      end
      mem_wr_full = 1'b0;
      send_range(8, 127, 2);
      mem_wr_empty = 1'b1;
      idle(5);
      n_cmp++;
      if (wr_log.size() != 0 || cmd_log.size() != 0 || boot_done !== 1'b0 || boot_error !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_frozen: got wr=%0d cmd=%0d done=%b err=%b required 0 0 0 1",
                  wr_log.size(), cmd_log.size(), boot_done, boot_error);
      end
   endtask

   task automatic test_cmd_full();
      int rel;
      do_reset();
      mem_cmd_full = 1'b1;
      send_range(0, 63, 2);
      send_range(64, 69, 2);
      idle(2);
      n_cmp++;
      if (cmd_log.size() != 0 || cmd_state_dbg !== 2'd1 || wr_log.size() != 17) begin
         n_fail++;
         $display("FAIL cmdfull_stall: got cmd=%0d state=%0d wr=%0d required 0 1 17",
                  cmd_log.size(), cmd_state_dbg, wr_log.size());
      end
      mem_cmd_full = 1'b0;
      rel = cyc;
      send_range(70, 127, 2);
      mem_wr_empty = 1'b1;
      idle(3);
      n_cmp++;
      if (cmd_cyc.size() == 0 || cmd_cyc[0] != rel || cmd_log[0] !== 30'h0) begin
         n_fail++;
         $display("FAIL cmdfull_first: got cycle %0d required %0d", (cmd_cyc.size() != 0) ? cmd_cyc[0] : -1, rel);
      end
      n_cmp++;
      if (cmd_log.size() != 2 || cmd_log[1] !== 30'h40 || wr_log.size() != 32) begin
         n_fail++;
         $display("FAIL cmdfull_second: got cmd=%0d wr=%0d required 2 32", cmd_log.size(), wr_log.size());
      end
      n_cmp++;
      if (boot_done !== 1'b1 || boot_error !== 1'b0) begin
         n_fail++;
         $display("FAIL cmdfull_done: got done=%b err=%b required 1 0", boot_done, boot_error);
      end
   endtask

   task automatic test_wr_error();
      do_reset();
      send_range(0, 49, 2);
      mem_wr_error = 1'b1;
      idle(1);
      mem_wr_error = 1'b0;
      n_cmp++;
      if (boot_error !== 1'b1) begin
         n_fail++;
         $display("FAIL wrerr_set: got err=%b required 1", boot_error);
      end
      send_range(50, 127, 2);
      mem_wr_empty = 1'b1;
      idle(5);
      n_cmp++;
      if (boot_error !== 1'b1 || boot_done !== 1'b0) begin
         n_fail++;
         $display("FAIL wrerr_sticky: got err=%b done=%b required 1 0", boot_error, boot_done);
      end
      n_cmp++;
      if (wr_log.size() != 12 || cmd_log.size() != 0) begin
         n_fail++;
         $display("FAIL wrerr_no_strobes: got wr=%0d cmd=%0d required 12 0", wr_log.size(), cmd_log.size());
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      send_range(0, 69, 2);
      do_reset();
      send_range(0, 127, 2);
      mem_wr_empty = 1'b1;
      idle(3);
      build_exp(32);
      n_cmp++;
      if (wr_log.size() != 32) begin
         n_fail++;
         $display("FAIL reload_count: got %0d required 32", wr_log.size());
      end
      for (int i = 0; i < 32 && i < wr_log.size(); i++) begin
         n_cmp++;
         if (wr_log[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL reload_word[%0d]: got %08h required %08h", i, wr_log[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (cmd_log.size() != 2 || cmd_log[0] !== 30'h0 || cmd_log[1] !== 30'h40) begin
         n_fail++;
         $display("FAIL reload_cmds: got count=%0d required 2 at 0 and 40", cmd_log.size());
      end
      n_cmp++;
      if (boot_done !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_done: got %b required 1", boot_done);
      end
   endtask

   task automatic test_after_done();
      clear_logs();
      send_range(200, 207, 1);
      idle(3);
      n_cmp++;
      if (wr_log.size() != 0 || cmd_log.size() != 0) begin
         n_fail++;
         $display("FAIL extra_bytes_strobes: got wr=%0d cmd=%0d required 0 0", wr_log.size(), cmd_log.size());
      end
      n_cmp++;
      if (boot_done !== 1'b1 || boot_error !== 1'b0) begin
         n_fail++;
         $display("FAIL extra_bytes_done: got done=%b err=%b required 1 0", boot_done, boot_error);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      #1;
      test_reset();
      test_basic_load();
      test_wr_full();
      test_cmd_full();
      test_wr_error();
      test_reset_mid_load();
      test_after_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
